// File: rtl/run_control_pkg.sv
// Shared state encoding for the run-control sequencer.
package run_control_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RC_RESET  = 2'b00,
    RC_RUN    = 2'b01,
    RC_HALTED = 2'b10,
    RC_STEP   = 2'b11
  } rcState_e;
endpackage

// File: rtl/button_conditioner.sv
// Pushbutton synchronizer, debouncer and press-edge pulse generator.
// Buttons are active-low; press is a single-cycle high pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btnRaw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stablePrev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      stable     <= 1'b1;
      stablePrev <= 1'b1;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      sync1      <= btnRaw;
      sync2      <= sync1;
      stablePrev <= stable;
      press      <= stablePrev & ~stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/run_control.sv
// Run-control sequencer: button conditioning, run/halt/step FSM
// and retired-instruction counter.
module run_control
  import run_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_cont,
  input  logic        btn_step,
  input  logic        btn_rst,
  input  logic        halt_instr,
  output logic        run_en,
  output logic        core_rst,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] instr_count
);
  logic     contPress;
  logic     stepPress;
  logic     rstPress;
  rcState_e cur;
  rcState_e nxt;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uCont (
    .clock (clock),
    .reset (reset),
    .btnRaw(btn_cont),
    .press (contPress)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStep (
    .clock (clock),
    .reset (reset),
    .btnRaw(btn_step),
    .press (stepPress)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRst (
    .clock (clock),
    .reset (reset),
    .btnRaw(btn_rst),
    .press (rstPress)
  );

  always_comb begin
    nxt      = cur;
    run_en   = 1'b0;
    core_rst = 1'b0;
    unique case (cur)
      RC_RESET: begin
        core_rst = 1'b1;
        nxt      = RC_RUN;
      end
      RC_RUN: begin
        run_en = ~halt_instr & ~stepPress;
        if (halt_instr || stepPress) nxt = RC_HALTED;
      end
      RC_HALTED: begin
        // cont steps past the instruction at PC in the pulse cycle
        if (contPress) begin
          run_en = ~rstPress;
          nxt    = RC_RUN;
        end else if (stepPress) begin
          nxt = RC_STEP;
        end
      end
      RC_STEP: begin
        run_en = 1'b1;
        nxt    = RC_HALTED;
      end
      default: nxt = RC_RESET;
    endcase
    if (rstPress) nxt = RC_RESET;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur         <= RC_RESET;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (core_rst) instr_count <= '0;
      else if (run_en) instr_count <= instr_count + 32'd1;
    end
  end

  assign halted = (cur == RC_HALTED);
  assign state  = cur;
endmodule

// File: doc/run_control.md
# run_control

Run-control sequencer for the single-cycle processor. It conditions the raw continue, step and soft-reset pushbuttons and combines them with the decoder's `Halt` signal. From these it produces the PC advance enable, a one-cycle core reset pulse and a retired-instruction counter. It sits between the board buttons and control decoder on one side and the PC/register-file write gating on the other, and replaces ad-hoc halt/continue gating.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a button level change is accepted (≥2).

Ports:
- `clock`  in  1  processor clock (divided clock); all logic on rising edge.
- `reset`  in  1  asynchronous, active-low, global reset.
- `btn_cont`  in  1  raw continue button, active-low, asynchronous to `clock`.
- `btn_step`  in  1  raw single-step button, active-low, asynchronous.
- `btn_rst`  in  1  raw soft-reset button, active-low, asynchronous.
- `halt_instr`  in  1  decoder `Halt` for the instruction currently at PC.
- `run_en`  out  1  PC may advance and architectural writes may commit this cycle.
- `core_rst`  out  1  reset pulse to the PC and LO/HI.
- `halted`  out  1  high in HALTED.
- `state`  out  2  FSM state, for debug LEDs.
- `instr_count`  out  32  count of cycles with `run_en`=1 since the last `core_rst`.

## Operation
- Each button passes through a 2-flop synchronizer with reset value 1 (released).
- Debounce per button:
  - The counter increments while the synchronized value ≠ the stable value, and clears otherwise.
  - On the cycle where it would reach `DEBOUNCE_CYCLES`, the stable value takes the synchronized value and the counter clears.
- Press pulse: one cycle high when the stable value falls 1→0. Release generates nothing.
- FSM states (encoding in package): RESET=00, RUN=01, HALTED=10, STEP=11.
  - RESET: `core_rst`=1, `run_en`=0; always → RUN next cycle.
  - RUN: `run_en`=~`halt_instr`.
    - `halt_instr`=1 → HALTED; the HALT instruction is not retired.
    - A step press → HALTED (pause), and `run_en`=0 that cycle.
    - A cont press is ignored.
  - HALTED: `run_en`=0.
    - A cont press → `run_en`=1 that same cycle (PC steps past the current instruction, HALT or not) and → RUN.
    - A step press → STEP.
  - STEP: `run_en`=1 for exactly one cycle regardless of `halt_instr`; → HALTED.
- Priority: a soft-reset press from any state → RESET next cycle, overriding all else. Cont and step pressed in the same cycle in HALTED: cont wins.
- `instr_count`: +1 on each cycle with `run_en`=1; cleared while `core_rst`=1; wraps modulo 2^32.
- `halted`=1 iff state=HALTED. `run_en` and `core_rst` are combinational from state, `halt_instr` and the press pulses.

## Timing
- Async reset asserted: state=RESET, `core_rst`=1, `run_en`=0, `halted`=0, `state`=00, `instr_count`=0, synchronizers/stable=1, counters=0. Outputs hold these values until the first edge after deassertion.
- The first cycle after reset release is RESET (`core_rst`=1); RUN starts on the second.
- Button latency: the press pulse is high for exactly one cycle, starting `DEBOUNCE_CYCLES`+2 rising edges after the first edge that samples the raw pin low. Glitches shorter than `DEBOUNCE_CYCLES` cycles yield no pulse.
- HALTED → RUN on cont: `run_en` is high in the pulse cycle itself (zero added latency).
- A reset press during STEP: the step cycle completes (`run_en`=1), then RESET.
- Holding a button produces one pulse only; a new pulse requires a release to be accepted first.

## Structure
- Package `run_control_pkg`: state localparams (`RC_RESET`, `RC_RUN`, `RC_HALTED`, `RC_STEP`) and the state width.
- Sub-module `button_conditioner` (synchronizer + debounce + fall-edge pulse, `DEBOUNCE_CYCLES` parameter), instantiated three times.
- The top level holds the FSM and `instr_count`.

## Test plan
- Reset release with `halt_instr`=0 → `core_rst`=1 for one cycle, then `run_en`=1. After 100 cycles `instr_count`=100, `state`=01.
- `halt_instr`=1 in RUN → same cycle `run_en`=0, next cycle `halted`=1. A cont press with `DEBOUNCE_CYCLES`=4 makes a pulse 6 edges after the pin goes low, with `run_en`=1 in that cycle, then RUN.
- In HALTED, a step press → exactly one `run_en` cycle, even with `halt_instr`=1; `instr_count` +1; back to HALTED.
- A 3-cycle low glitch on `btn_cont` (`DEBOUNCE_CYCLES`=4) → no pulse, remains HALTED. Holding the button 50 cycles → exactly one pulse.
- Cont and step press in the same cycle while HALTED → RUN. A soft-reset press in RUN with `instr_count`=37 → RESET, `core_rst` for one cycle, `instr_count`=0.
- Async `reset` low mid-STEP → immediate `run_en`=0, `core_rst`=1, `state`=00, independent of `clock`.
